// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
// Next-PC redirect controller for the fetch stage. Picks one redirect per
// cycle from trap / mret / EX branch / ID jump (in that priority order). It
// drives the PC register's load strobe and load address, and its increment
// enable. If fetch cannot take the redirect yet, the redirect is held until
// it can. Each issued redirect is followed by a fixed-length pipeline flush.
//
// Parameters:
//   FLUSH_CYCLES  cycles flush_if/flush_id stay high per issued redirect (1..15)
//   RESET_PC      value presented on o_set_addr out of reset
//
// Build option:
//   PC_REDIRECT_MISALIGN_CHK_EN  when defined, a br/jmp target with bit[1] set
//     is not issued. Instead it raises a one-cycle o_misalign_exc carrying
//     the target. When undefined, every target is issued with bits[1:0]
//     cleared, and the misalign outputs are tied to 0.
//
// Ports:
//   clk, rst                   clock; synchronous active-low reset
//   i_trap_req/i_trap_addr     trap or interrupt entry (highest priority)
//   i_mret_req/i_mret_addr     return from trap (mepc)
//   i_br_req/i_br_target       EX-stage taken branch
//   i_jmp_req/i_jmp_target     ID-stage jal/jalr (lowest priority)
//   i_fetch_ready              instruction bus accepts a new address this cycle
//   i_stall                    pipeline hazard stall
//   o_pc_en                    PC increment enable
//   o_set_en/o_set_addr        one-cycle PC load strobe and load value
//   o_flush_if/o_flush_id      kill IF/ID and ID/EX registers
//   o_redirect_pending         a redirect is held, waiting for fetch_ready
//   o_misalign_exc/_addr       misaligned br/jmp target pulse and address
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | no redirect in progress
// HOLD   | redirect latched, waiting for fetch_ready
// FLUSH  | redirect issued, flush counter running

module pc_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_trap_req,
  input  logic [31:0] i_trap_addr,
  input  logic        i_mret_req,
  input  logic [31:0] i_mret_addr,
  input  logic        i_br_req,
  input  logic [31:0] i_br_target,
  input  logic        i_jmp_req,
  input  logic [31:0] i_jmp_target,
  input  logic        i_fetch_ready,
  input  logic        i_stall,
  output logic        o_pc_en,
  output logic        o_set_en,
  output logic [31:0] o_set_addr,
  output logic        o_flush_if,
  output logic        o_flush_id,
  output logic        o_redirect_pending,
  output logic        o_misalign_exc,
  output logic [31:0] o_misalign_addr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  // Larger value wins; trap and mret share bit[1]=1, which is also what
  // marks them as exempt from the misalignment check.
  localparam logic [1:0] PRI_JMP  = 2'd0;
  localparam logic [1:0] PRI_BR   = 2'd1;
  localparam logic [1:0] PRI_MRET = 2'd2;
  localparam logic [1:0] PRI_TRAP = 2'd3;

  localparam logic [3:0] FLUSH_LOAD = FLUSH_CYCLES[3:0];

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic [3:0]  w_next_cnt;
  logic [31:0] r_hold_addr;
  logic [31:0] w_next_hold_addr;
  logic [1:0]  r_hold_pri;
  logic [1:0]  w_next_hold_pri;
  logic        r_set_en;
  logic [31:0] r_set_addr;

  logic        w_win_valid;
  logic [1:0]  w_win_pri;
  logic [31:0] w_win_raw;
  logic [31:0] w_win_addr;
  logic        w_win_misalign;
  logic        w_higher;
  logic        w_issue;
  logic [31:0] w_issue_addr;

  // Fixed-priority pick; losers in the same cycle are simply forgotten.
  always_comb begin
    w_win_valid = 1'b1;
    w_win_pri   = PRI_JMP;
    w_win_raw   = i_jmp_target;
    if (i_trap_req) begin
      w_win_pri = PRI_TRAP;
      w_win_raw = i_trap_addr;
    end else if (i_mret_req) begin
      w_win_pri = PRI_MRET;
      w_win_raw = i_mret_addr;
    end else if (i_br_req) begin
      w_win_pri = PRI_BR;
      w_win_raw = i_br_target;
    end else if (!i_jmp_req) begin
      w_win_valid = 1'b0;
    end
  end

  assign w_higher = w_win_valid && (w_win_pri > r_hold_pri);

`ifdef PC_REDIRECT_MISALIGN_CHK_EN
  logic        w_misalign_hit;
  logic        r_misalign_exc;
  logic [31:0] r_misalign_addr;

  assign w_win_misalign = w_win_valid & ~w_win_pri[1] & w_win_raw[1];
  assign w_win_addr     = w_win_raw;
  // In HOLD only a request that would otherwise override counts as seen.
  assign w_misalign_hit = w_win_misalign & ((r_state != S_HOLD) | w_higher);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_misalign_exc  <= 1'b0;
      r_misalign_addr <= '0;
    end else begin
      r_misalign_exc <= w_misalign_hit;
      if (w_misalign_hit) r_misalign_addr <= w_win_addr;
    end
  end

  assign o_misalign_exc  = r_misalign_exc;
  assign o_misalign_addr = r_misalign_addr;
`else
  assign w_win_misalign  = 1'b0;
  assign w_win_addr      = w_win_raw & 32'hFFFF_FFFC;
  assign o_misalign_exc  = 1'b0;
  assign o_misalign_addr = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hold_addr <= '0;
      r_hold_pri  <= PRI_JMP;
      r_set_en    <= 1'b0;
      r_set_addr  <= RESET_PC;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_hold_addr <= w_next_hold_addr;
      r_hold_pri  <= w_next_hold_pri;
      r_set_en    <= w_issue;
      if (w_issue) r_set_addr <= w_issue_addr;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_next_cnt       = r_cnt;
    w_next_hold_addr = r_hold_addr;
    w_next_hold_pri  = r_hold_pri;
    w_issue          = 1'b0;
    w_issue_addr     = r_set_addr;

    case (r_state)
      S_HOLD: begin
        if (w_higher && !w_win_misalign) begin
          w_next_hold_addr = w_win_addr;
          w_next_hold_pri  = w_win_pri;
        end
        if (i_fetch_ready) begin
          w_issue      = 1'b1;
          w_issue_addr = (w_higher && !w_win_misalign) ? w_win_addr : r_hold_addr;
        end
      end
      default: begin
        if (r_state == S_FLUSH) begin
          w_next_cnt = r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            w_next_state = S_IDLE;
            w_next_cnt   = '0;
          end
        end
        if (w_win_valid && !w_win_misalign) begin
          if (i_fetch_ready) begin
            w_issue      = 1'b1;
            w_issue_addr = w_win_addr;
          end else begin
            w_next_state     = S_HOLD;
            w_next_cnt       = '0;
            w_next_hold_addr = w_win_addr;
            w_next_hold_pri  = w_win_pri;
          end
        end
      end
    endcase

    // Any issue (fresh or from HOLD) restarts the flush window.
    if (w_issue) begin
      w_next_state = S_FLUSH;
      w_next_cnt   = FLUSH_LOAD;
    end
  end

  always_comb begin
    o_set_en           = r_set_en;
    o_set_addr         = r_set_addr;
    o_flush_if         = (r_state == S_FLUSH);
    o_flush_id         = (r_state == S_FLUSH);
    o_redirect_pending = (r_state == S_HOLD);
    // A pending or just-issued redirect owns the PC; never increment then.
    o_pc_en            = i_fetch_ready & ~i_stall & (r_state != S_HOLD) & ~r_set_en;
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
module tb_pc_redirect_ctrl;

  logic        clk;
  logic        rst;
  logic        trap_req, mret_req, br_req, jmp_req;
  logic [31:0] trap_addr, mret_addr, br_target, jmp_target;
  logic        fetch_ready, stall;
  logic        pc_en, set_en, flush_if, flush_id, redirect_pending, misalign_exc;
  logic [31:0] set_addr, misalign_addr;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  pc_redirect_ctrl #(.FLUSH_CYCLES(2), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .i_trap_req(trap_req), .i_trap_addr(trap_addr),
    .i_mret_req(mret_req), .i_mret_addr(mret_addr),
    .i_br_req(br_req), .i_br_target(br_target),
    .i_jmp_req(jmp_req), .i_jmp_target(jmp_target),
    .i_fetch_ready(fetch_ready), .i_stall(stall),
    .o_pc_en(pc_en), .o_set_en(set_en), .o_set_addr(set_addr),
    .o_flush_if(flush_if), .o_flush_id(flush_id),
    .o_redirect_pending(redirect_pending),
    .o_misalign_exc(misalign_exc), .o_misalign_addr(misalign_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every cycle: set_en/pc_en exclusivity, and each set_en pulse consumes one
  // expected address from the scoreboard.
  task automatic observe();
    logic [31:0] exp_addr;
    chk("set_pc_excl", {31'b0, set_en & pc_en}, 32'h0);
    chk("flush_id_eq_if", {31'b0, flush_id}, {31'b0, flush_if});
    if (set_en === 1'b1) begin
      chk("sb_nonempty", {31'b0, exp_q.size() != 0}, 32'h1);
      if (exp_q.size() != 0) begin
        exp_addr = exp_q.pop_front();
        chk("sb_set_addr", set_addr, exp_addr);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    observe();
  endtask

  task automatic clear_reqs();
    trap_req = 1'b0; mret_req = 1'b0; br_req = 1'b0; jmp_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0; fetch_ready = 1'b1; stall = 1'b0;
    clear_reqs();
    trap_addr = '0; mret_addr = '0; br_target = '0; jmp_target = '0;
    step(); step();
    chk("rst_set_addr", set_addr, 32'h0);
    chk("rst_set_en", {31'b0, set_en}, 32'h0);
    chk("rst_flush", {31'b0, flush_if}, 32'h0);
    chk("rst_pending", {31'b0, redirect_pending}, 32'h0);
    chk("rst_misalign", {31'b0, misalign_exc}, 32'h0);
    chk("rst_misalign_addr", misalign_addr, 32'h0);
    rst = 1'b1;

    // idle
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_pc_en", {31'b0, pc_en}, 32'h1);
      chk("idle_set_en", {31'b0, set_en}, 32'h0);
      chk("idle_flush", {31'b0, flush_if}, 32'h0);
      chk("idle_set_addr", set_addr, 32'h0);
    end

    // branch, single issue with 2-cycle flush
    br_req = 1'b1; br_target = 32'h100; exp_q.push_back(32'h100);
    step(); clear_reqs();
    chk("br_set_en", {31'b0, set_en}, 32'h1);
    chk("br_pc_en", {31'b0, pc_en}, 32'h0);
    chk("br_flush1", {31'b0, flush_if}, 32'h1);
    step();
    chk("br_set_en_pulse", {31'b0, set_en}, 32'h0);
    chk("br_flush2", {31'b0, flush_if}, 32'h1);
    chk("br_pc_en2", {31'b0, pc_en}, 32'h1);
    step();
    chk("br_flush_end", {31'b0, flush_if}, 32'h0);
    chk("br_set_addr_hold", set_addr, 32'h100);

    // trap beats jump in the same cycle
    trap_req = 1'b1; trap_addr = 32'h80; jmp_req = 1'b1; jmp_target = 32'h40;
    exp_q.push_back(32'h80);
    step(); clear_reqs();
    chk("trap_set_en", {31'b0, set_en}, 32'h1);
    step(); step(); step();
    chk("trap_idle", {31'b0, flush_if}, 32'h0);

    // hold: jmp then higher br while fetch not ready
    fetch_ready = 1'b0; jmp_req = 1'b1; jmp_target = 32'h40;
    step(); clear_reqs();
    chk("hold_pending1", {31'b0, redirect_pending}, 32'h1);
    chk("hold_no_set", {31'b0, set_en}, 32'h0);
    br_req = 1'b1; br_target = 32'h200;
    step(); clear_reqs();
    chk("hold_pending2", {31'b0, redirect_pending}, 32'h1);
    step();
    chk("hold_pending3", {31'b0, redirect_pending}, 32'h1);
    step();
    chk("hold_pending4", {31'b0, redirect_pending}, 32'h1);
    fetch_ready = 1'b1; #1;
    chk("hold_pc_en_blocked", {31'b0, pc_en}, 32'h0);
    exp_q.push_back(32'h200);
    step();
    chk("hold_issue", {31'b0, set_en}, 32'h1);
    chk("hold_released", {31'b0, redirect_pending}, 32'h0);
    chk("hold_flush", {31'b0, flush_if}, 32'h1);
    step(); step();

    // lower priority dropped while held
    fetch_ready = 1'b0; br_req = 1'b1; br_target = 32'h900;
    step(); clear_reqs();
    jmp_req = 1'b1; jmp_target = 32'hA00;
    step(); clear_reqs();
    fetch_ready = 1'b1; exp_q.push_back(32'h900);
    step();
    chk("drop_low_issue", {31'b0, set_en}, 32'h1);
    step(); step();

    // mret during second flush cycle extends the window
    br_req = 1'b1; br_target = 32'h500; exp_q.push_back(32'h500);
    step(); clear_reqs();
    step();
    chk("ext_flush2", {31'b0, flush_if}, 32'h1);
    mret_req = 1'b1; mret_addr = 32'h300; exp_q.push_back(32'h300);
    step(); clear_reqs();
    chk("ext_set_en", {31'b0, set_en}, 32'h1);
    chk("ext_flush3", {31'b0, flush_if}, 32'h1);
    step();
    chk("ext_flush4", {31'b0, flush_if}, 32'h1);
    step();
    chk("ext_flush_end", {31'b0, flush_if}, 32'h0);

    // stall does not delay a redirect
    stall = 1'b1; jmp_req = 1'b1; jmp_target = 32'h600; exp_q.push_back(32'h600);
    step(); clear_reqs();
    chk("stall_set_en", {31'b0, set_en}, 32'h1);
    step();
    chk("stall_pc_en", {31'b0, pc_en}, 32'h0);
    stall = 1'b0;
    step();

    // back-to-back pulses
    br_req = 1'b1; br_target = 32'h700; exp_q.push_back(32'h700);
    step();
    br_target = 32'h704; exp_q.push_back(32'h704);
    chk("b2b_first", {31'b0, set_en}, 32'h1);
    step(); clear_reqs();
    chk("b2b_second", {31'b0, set_en}, 32'h1);
    step();
    chk("b2b_gap", {31'b0, set_en}, 32'h0);
    step(); step();

    // misaligned targets
    jmp_req = 1'b1; jmp_target = 32'h42;
`ifndef PC_REDIRECT_MISALIGN_CHK_EN
    exp_q.push_back(32'h40);
`endif
    step(); clear_reqs();
`ifdef PC_REDIRECT_MISALIGN_CHK_EN
    chk("mis_set_en", {31'b0, set_en}, 32'h0);
    chk("mis_exc", {31'b0, misalign_exc}, 32'h1);
    chk("mis_addr", misalign_addr, 32'h42);
    chk("mis_no_flush", {31'b0, flush_if}, 32'h0);
    step();
    chk("mis_exc_pulse", {31'b0, misalign_exc}, 32'h0);
`else
    chk("mis_set_en", {31'b0, set_en}, 32'h1);
    chk("mis_exc_tied", {31'b0, misalign_exc}, 32'h0);
    step(); step();
`endif
    step();
    trap_req = 1'b1; trap_addr = 32'h83;
`ifdef PC_REDIRECT_MISALIGN_CHK_EN
    exp_q.push_back(32'h83);
`else
    exp_q.push_back(32'h80);
`endif
    step(); clear_reqs();
    chk("trap_unchk_set_en", {31'b0, set_en}, 32'h1);
    step(); step();

    // reset discards a held redirect
    fetch_ready = 1'b0; trap_req = 1'b1; trap_addr = 32'hB00;
    step(); clear_reqs();
    chk("rst2_pending_pre", {31'b0, redirect_pending}, 32'h1);
    rst = 1'b0;
    step();
    chk("rst2_pending", {31'b0, redirect_pending}, 32'h0);
    chk("rst2_set_addr", set_addr, 32'h0);
    rst = 1'b1; fetch_ready = 1'b1;
    step();
    chk("rst2_no_issue", {31'b0, set_en}, 32'h0);
    step();
    chk("rst2_no_issue2", {31'b0, set_en}, 32'h0);

    chk("sb_drained", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Next-PC redirect controller for the core's fetch stage. It arbitrates redirect requests from trap entry, `mret`, EX-stage branches and ID-stage jumps, and drives the PC register's load port (`set_en`/`set_addr`) and increment enable (`pc_en`). A redirect that arrives while fetch is not ready is held until fetch accepts it. After each redirect, the controller asserts pipeline flush for a fixed number of cycles to kill wrong-path instructions.

## Interface
- `FLUSH_CYCLES`, default 2: number of cycles `flush_if`/`flush_id` stay high after a redirect issues (legal range 1..15).
- `RESET_PC`, default 32'h0000_0000: value `set_addr` holds after reset.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-low.
- `trap_req`  in  1  trap or interrupt entry (highest priority).
- `trap_addr`  in  32  trap vector.
- `mret_req`  in  1  return from trap.
- `mret_addr`  in  32  mepc value.
- `br_req`  in  1  EX-stage branch taken.
- `br_target`  in  32  branch target.
- `jmp_req`  in  1  ID-stage jal/jalr (lowest priority).
- `jmp_target`  in  32  jump target.
- `fetch_ready`  in  1  instruction bus can accept a new address this cycle.
- `stall`  in  1  hazard stall from the pipeline.
- `pc_en`  out  1  PC increment enable.
- `set_en`  out  1  PC load strobe, one cycle.
- `set_addr`  out  32  PC load value.
- `flush_if`  out  1  kill the IF/ID register.
- `flush_id`  out  1  kill the ID/EX register.
- `redirect_pending`  out  1  a redirect is latched and waiting for `fetch_ready`.
- `misalign_exc`  out  1  misaligned-target pulse (see Configuration).
- `misalign_addr`  out  32  offending target.

## Operation
- Priority, evaluated combinationally each cycle: trap > mret > br > jmp. Only the winner is considered.
- States:
  - IDLE: no redirect in progress.
  - HOLD: redirect latched, waiting for `fetch_ready`.
  - FLUSH: counter running.
- IDLE, or FLUSH, with a winning request:
  - If `fetch_ready=1`: register `set_en=1` and `set_addr=target` for the next cycle, load the flush counter with `FLUSH_CYCLES`, and go to FLUSH.
  - If `fetch_ready=0`: latch the target and its priority, and go to HOLD.
- HOLD:
  - A new request of strictly higher priority overwrites the latched target. Equal or lower priority requests are dropped.
  - When `fetch_ready=1`, issue the latched (or overriding) target as above and go to FLUSH.
- FLUSH:
  - Counter decrements each cycle; return to IDLE when it reaches 0.
  - A new redirect during FLUSH reissues and reloads the counter to `FLUSH_CYCLES`.
- Outputs:
  - `flush_if`/`flush_id` = (state==FLUSH), registered.
  - `pc_en` = `fetch_ready & ~stall & ~redirect_pending & ~set_en`, combinational.
  - `set_en` has priority over `pc_en` at the PC register; both are never high together.
- Arithmetic: targets are passed through unmodified except for alignment handling. No offset arithmetic occurs here.
- Reset (rst=0 at a clock edge):
  - state=IDLE, counter=0.
  - `set_en=0`, `set_addr=RESET_PC`, `flush_*=0`, `redirect_pending=0`, `misalign_exc=0`, `misalign_addr=0`.
  - A latched redirect is discarded.

## Timing
- Latency: a request sampled at edge N with `fetch_ready=1` gives `set_en=1` during cycle N+1. The PC loads at the end of N+1.
- `set_en` is a single-cycle pulse per issued redirect. Back-to-back requests give pulses in consecutive cycles.
- Flush window: `flush_*` is high for cycles N+1 .. N+`FLUSH_CYCLES`.
- `stall` does not delay a redirect; only `fetch_ready` does.
- `redirect_pending` is high for every cycle spent in HOLD.
- Simultaneous requests in one cycle: only the highest priority is issued; the others are not remembered.

## Configuration
- `PC_REDIRECT_MISALIGN_CHK_EN` defined:
  - A br/jmp target with bit[1]=1 is not issued.
  - Instead, `misalign_exc` pulses for one cycle, at the same latency as `set_en`, with `misalign_addr=target`. State stays unchanged.
  - trap/mret targets are never checked.
- Not defined:
  - Every target is issued with bits[1:0] forced to 0.
  - `misalign_exc` and `misalign_addr` are tied to 0.

## Test plan
- Reset then idle with `fetch_ready=1`, `stall=0` -> `set_addr`=0, `set_en`=0, `pc_en`=1 every cycle, flush signals low.
- `br_req` with `br_target`=0x100 and `fetch_ready=1` -> `set_en`=1 with `set_addr`=0x100 exactly one cycle later; `flush_if` high for 2 cycles; `pc_en`=0 during the `set_en` cycle.
- `trap_req` (0x80) and `jmp_req` (0x40) in the same cycle -> a single `set_en` with `set_addr`=0x80; the jump is never issued.
- `fetch_ready`=0 with `jmp_req` (0x40), then `br_req` (0x200) the next cycle, then `fetch_ready`=1 after 3 cycles -> `redirect_pending` high throughout HOLD; one `set_en` issued with 0x200.
- New `mret_req` (0x300) on the second FLUSH cycle -> `set_en` with 0x300; flush extended to 2 cycles beyond the new issue.
- With the macro defined, `jmp_target`=0x42 -> `misalign_exc` pulse with `misalign_addr`=0x42 and no `set_en`. Without the macro, the same stimulus -> `set_en` with `set_addr`=0x40.
